mlp_stream_engine: RTL and testbench

Parametrised single-layer fully-connected engine: y = requant(W·x + b) for int8 activations/weights and int32 bias, with a configurable input length, output length and lane count. It replaces the fixed 8×8, two-mode MLP datapath with a streaming design: ifmap is buffered once, bias and weights stream from DRAM over a valid/ready port, and results leave over a valid/ready port with backpressure. It sits between the DRAM loader and the ofmap writer, and is chained layer-by-layer by the host.

---
 rtl/mlp_stream_engine_pkg.sv | 27 ++
 rtl/mlp_stream_engine_if.sv | 22 ++
 rtl/mlp_stream_engine_requant.sv | 39 +++
 rtl/mlp_stream_engine.sv | 214 +++++++++++++++++++++
 tb/tb_mlp_stream_engine.sv | 266 ++++++++++++++++++++++++++
 5 files changed

// File: rtl/mlp_stream_engine_pkg.sv
// Shared types and helpers for the streaming fully-connected layer engine.
package mlp_stream_pkg;

  localparam int ACC_W  = 32;
  localparam int BEAT_W = 32;

  typedef enum logic [2:0] {
    IDLE,
    LOAD_X,
    LOAD_B,
    MAC,
    DRAIN,
    DONE
  } state_e;

  // Clamp a wide signed value into int8 range, returned sign-extended to 32 bits.
  function automatic logic [ACC_W-1:0] sat8(input logic signed [63:0] v);
    if (v > 64'sd127) begin
      return 32'h0000_007F;
    end else if (v < -64'sd128) begin
      return 32'hFFFF_FF80;
    end else begin
      return v[ACC_W-1:0];
    end
  endfunction

endpackage

// File: rtl/mlp_stream_engine_if.sv
// Input beat stream (ifmap/bias/weights) and output result stream of the engine.
interface mlp_stream_engine_if;
  import mlp_stream_pkg::*;

  logic              s_valid;
  logic              s_ready;
  logic [BEAT_W-1:0] s_data;
  logic              m_valid;
  logic              m_ready;
  logic [BEAT_W-1:0] m_data;

  modport slave (
    input  s_valid, s_data, m_ready,
    output s_ready, m_valid, m_data
  );

  modport master (
    output s_valid, s_data, m_ready,
    input  s_ready, m_valid, m_data
  );

endinterface

// File: rtl/mlp_stream_engine_requant.sv
// Combinational output stage: raw accumulator pass-through or rounded int8 requantisation.
module requant_int8
  import mlp_stream_pkg::*;
#(
  parameter int SCALE_W = 12,
  parameter int SHIFT   = 12
) (
  input  logic [ACC_W-1:0]   acc_i,
  input  logic [SCALE_W-1:0] scale_i,
  input  logic               relu_en_i,
  input  logic               mode_i,
  output logic [ACC_W-1:0]   result_o
);

  localparam int PW = ACC_W + SCALE_W + 1;
  localparam logic signed [PW-1:0] HALF = {{(PW-SHIFT){1'b0}}, 1'b1, {(SHIFT-1){1'b0}}};

  logic signed [PW-1:0] prod;
  logic signed [PW-1:0] rounded;
  logic signed [PW-1:0] shifted;
  logic signed [63:0]   q;

  // The scale is unsigned, so it gets a zero sign bit before the signed multiply.
  always_comb begin
    prod    = PW'($signed(acc_i)) * PW'($signed({1'b0, scale_i}));
    rounded = prod + HALF;
    shifted = rounded >>> SHIFT;
    q       = 64'(shifted);
    if (relu_en_i && (q < 0)) begin
      q = '0;
    end
    if (mode_i) begin
      result_o = (relu_en_i && acc_i[ACC_W-1]) ? '0 : acc_i;
    end else begin
      result_o = sat8(q);
    end
  end

endmodule

// File: rtl/mlp_stream_engine.sv
// Streaming single-layer FC engine: buffers the ifmap once, then per LANES-neuron group
// loads biases, accumulates streamed weights and drains requantised results.
module mlp_stream_engine
  import mlp_stream_pkg::*;
#(
  parameter int LANES   = 8,
  parameter int IN_MAX  = 64,
  parameter int SCALE_W = 12,
  parameter int SHIFT   = 12
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    start,
  input  logic                    mode,
  input  logic                    relu_en,
  input  logic [$clog2(IN_MAX):0] in_len,
  input  logic [15:0]             out_len,
  input  logic [SCALE_W-1:0]      scaling_factor,
  mlp_stream_engine_if.slave      bus,
  output logic                    busy,
  output logic                    done
);

  localparam int XW = $clog2(IN_MAX);
  localparam int KW = XW + 1;
  localparam int LW = $clog2(LANES);
  localparam int NB = LANES / 4;
  localparam int MW = (NB > 1) ? $clog2(NB) : 1;

  state_e              state_q, state_d;
  logic [KW-1:0]       inLen_q, inLen_d, cnt_q, cnt_d;
  logic [KW-1:0]       inMasked, inEff;
  logic [15:0]         numGroups_q, numGroups_d, group_q, group_d, outGroups;
  logic                mode_q, mode_d, relu_q, relu_d;
  logic [SCALE_W-1:0]  scale_q, scale_d;
  logic [MW-1:0]       sub_q, sub_d;
  logic [LW-1:0]       lane_q, lane_d;
  logic [ACC_W-1:0]    acc_q [LANES];
  logic [ACC_W-1:0]    acc_d [LANES];
  logic signed [7:0]   xBuf_q [IN_MAX];
  logic signed [7:0]   xk;
  logic [ACC_W-1:0]    mData_q, mData_d, reqAcc, reqResult;
  logic                sReady, sFire, mFire, loadOut;

  assign inMasked  = in_len & ~KW'(3);
  assign inEff     = (inMasked > KW'(IN_MAX)) ? KW'(IN_MAX) : inMasked;
  assign outGroups = out_len >> LW;

  assign sReady = (state_q == LOAD_X) || (state_q == LOAD_B) || (state_q == MAC);
  assign sFire  = bus.s_valid && sReady;
  assign mFire  = (state_q == DRAIN) && bus.m_ready;
  assign xk     = xBuf_q[cnt_q[XW-1:0]];

  assign bus.s_ready = sReady;
  assign bus.m_valid = (state_q == DRAIN);
  assign bus.m_data  = mData_q;
  assign busy        = (state_q != IDLE);
  assign done        = (state_q == DONE);

  // The output register is fed from the next-state accumulators so the lane that
  // completes on the final MAC beat is already correct when DRAIN starts.
  assign reqAcc  = acc_d[lane_d];
  assign mData_d = loadOut ? reqResult : mData_q;

  requant_int8 #(
    .SCALE_W(SCALE_W),
    .SHIFT  (SHIFT)
  ) uRequant (
    .acc_i    (reqAcc),
    .scale_i  (scale_q),
    .relu_en_i(relu_q),
    .mode_i   (mode_q),
    .result_o (reqResult)
  );

  always_comb begin
    state_d     = state_q;
    inLen_d     = inLen_q;
    numGroups_d = numGroups_q;
    mode_d      = mode_q;
    relu_d      = relu_q;
    scale_d     = scale_q;
    cnt_d       = cnt_q;
    sub_d       = sub_q;
    lane_d      = lane_q;
    group_d     = group_q;
    acc_d       = acc_q;
    loadOut     = 1'b0;

    case (state_q)
      IDLE: begin
        if (start) begin
          inLen_d     = inEff;
          numGroups_d = outGroups;
          mode_d      = mode;
          relu_d      = relu_en;
          scale_d     = scaling_factor;
          cnt_d       = '0;
          sub_d       = '0;
          lane_d      = '0;
          group_d     = '0;
          state_d     = ((inEff == '0) || (outGroups == '0)) ? DONE : LOAD_X;
        end
      end
      LOAD_X: begin
        if (sFire) begin
          cnt_d = cnt_q + KW'(1);
          if (cnt_q == (inLen_q >> 2) - KW'(1)) begin
            cnt_d   = '0;
            lane_d  = '0;
            state_d = LOAD_B;
          end
        end
      end
      LOAD_B: begin
        if (sFire) begin
          for (int l = 0; l < LANES; l++) begin
            if (LW'(l) == lane_q) acc_d[l] = bus.s_data;
          end
          lane_d = lane_q + LW'(1);
          if (lane_q == LW'(LANES - 1)) begin
            lane_d  = '0;
            cnt_d   = '0;
            sub_d   = '0;
            state_d = MAC;
          end
        end
      end
      MAC: begin
        if (sFire) begin
          for (int l = 0; l < LANES; l++) begin
            if ((l / 4) == int'(sub_q)) begin
              acc_d[l] = acc_q[l] + ACC_W'(xk * $signed(bus.s_data[8*(l%4) +: 8]));
            end
          end
          if (sub_q == MW'(NB - 1)) begin
            sub_d = '0;
            cnt_d = cnt_q + KW'(1);
            if (cnt_q == inLen_q - KW'(1)) begin
              cnt_d   = '0;
              lane_d  = '0;
              loadOut = 1'b1;
              state_d = DRAIN;
            end
          end else begin
            sub_d = sub_q + MW'(1);
          end
        end
      end
      DRAIN: begin
        if (mFire) begin
          if (lane_q == LW'(LANES - 1)) begin
            lane_d = '0;
            if (group_q == numGroups_q - 16'd1) begin
              state_d = DONE;
            end else begin
              group_d = group_q + 16'd1;
              state_d = LOAD_B;
            end
          end else begin
            lane_d  = lane_q + LW'(1);
            loadOut = 1'b1;
          end
        end
      end
      DONE: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      inLen_q     <= '0;
      numGroups_q <= '0;
      mode_q      <= 1'b0;
      relu_q      <= 1'b0;
      scale_q     <= '0;
      cnt_q       <= '0;
      sub_q       <= '0;
      lane_q      <= '0;
      group_q     <= '0;
      mData_q     <= '0;
      for (int l = 0; l < LANES; l++) acc_q[l] <= '0;
    end else begin
      state_q     <= state_d;
      inLen_q     <= inLen_d;
      numGroups_q <= numGroups_d;
      mode_q      <= mode_d;
      relu_q      <= relu_d;
      scale_q     <= scale_d;
      cnt_q       <= cnt_d;
      sub_q       <= sub_d;
      lane_q      <= lane_d;
      group_q     <= group_d;
      mData_q     <= mData_d;
      acc_q       <= acc_d;
    end
  end

  // The ifmap buffer is deliberately left out of reset; it is always rewritten before use.
  always_ff @(posedge clk) begin
    if ((state_q == LOAD_X) && sFire) begin
      for (int j = 0; j < 4; j++) begin
        xBuf_q[{cnt_q[XW-3:0], 2'(j)}] <= bus.s_data[8*j +: 8];
      end
    end
  end

endmodule

// File: tb/tb_mlp_stream_engine.sv
// Directed self-checking bench for mlp_stream_engine (LANES=8, IN_MAX=64).
module tb_mlp_stream_engine;
  import mlp_stream_pkg::*;

  localparam int LANES  = 8;
  localparam int IN_MAX = 64;

  logic        clk = 1'b0;
  logic        rst, start, mode, reluEn;
  logic [6:0]  inLen;
  logic [15:0] outLen;
  logic [11:0] scale;
  logic        busy, done;

  int checkCount = 0;
  int passCount  = 0;

  int          xv [64];
  int          wv [16][64];
  int          bv [16];
  logic [31:0] expQ [16];

  mlp_stream_engine_if bus ();

  mlp_stream_engine #(
    .LANES  (LANES),
    .IN_MAX (IN_MAX),
    .SCALE_W(12),
    .SHIFT  (12)
  ) dut (
    .clk           (clk),
    .rst           (rst),
    .start         (start),
    .mode          (mode),
    .relu_en       (reluEn),
    .in_len        (inLen),
    .out_len       (outLen),
    .scaling_factor(scale),
    .bus           (bus),
    .busy          (busy),
    .done          (done)
  );

  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("[TB] FAIL watchdog: simulation did not finish");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    checkCount++;
    if (observed === expected) passCount++;
    else $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h", tag, observed, expected);
  endtask

  task automatic flagTimeout(input string tag);
    checkCount++;
    $display("[TB] FAIL %s_timeout: got no handshake, expected one within bound", tag);
  endtask

  function automatic logic [31:0] pack4(input int a, input int b, input int c, input int d);
    return {d[7:0], c[7:0], b[7:0], a[7:0]};
  endfunction

  // All tasks start and end on a falling edge.
  task automatic applyStimulus(input int inL, input int outL, input logic md, input logic relu, input int sc);
    inLen  = 7'(inL);
    outLen = 16'(outL);
    mode   = md;
    reluEn = relu;
    scale  = 12'(sc);
    start  = 1'b1;
    @(negedge clk);
    start  = 1'b0;
  endtask

  task automatic sendBeat(input logic [31:0] d, input string tag);
    int t = 0;
    bus.s_valid = 1'b1;
    bus.s_data  = d;
    while (bus.s_ready !== 1'b1 && t < 50) begin
      @(negedge clk);
      t++;
    end
    if (t >= 50) flagTimeout(tag);
    @(negedge clk);
    bus.s_valid = 1'b0;
  endtask

  task automatic idle(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic recvGroup(input int base, input bit toggle, input string tag);
    int          got = 0;
    int          t = 0;
    bit          phase = 1'b1;
    bit          stalled = 1'b0;
    logic [31:0] held = '0;
    while (got < LANES && t < 200) begin
      bus.m_ready = toggle ? phase : 1'b1;
      if (stalled) begin
        checkOutput({tag, "_hold"}, bus.m_data, held);
        stalled = 1'b0;
      end
      if (got > 0) checkOutput({tag, "_noBubble"}, 32'(bus.m_valid), 32'd1);
      if (bus.m_valid) begin
        if (bus.m_ready) begin
          checkOutput($sformatf("%s_lane%0d", tag, base + got), bus.m_data, expQ[base + got]);
          got++;
        end else begin
          held    = bus.m_data;
          stalled = 1'b1;
        end
      end
      @(negedge clk);
      t++;
      phase = ~phase;
    end
    if (got < LANES) flagTimeout(tag);
    bus.m_ready = 1'b1;
  endtask

  task automatic sendGroupInputs(input int g, input int inEff, input int gap, input string tag);
    for (int l = 0; l < LANES; l++) sendBeat(bv[g*LANES + l], tag);
    for (int k = 0; k < inEff; k++) begin
      for (int m = 0; m < LANES/4; m++) begin
        idle(gap);
        sendBeat(pack4(wv[g*LANES + 4*m][k], wv[g*LANES + 4*m + 1][k],
                       wv[g*LANES + 4*m + 2][k], wv[g*LANES + 4*m + 3][k]), tag);
      end
    end
  endtask

  task automatic runJob(input int inL, input int outL, input logic md, input logic relu,
                        input int sc, input int gap, input bit toggle, input string tag);
    int inEff = inL & ~3;
    int groups = outL / LANES;
    if (inEff > IN_MAX) inEff = IN_MAX;
    applyStimulus(inL, outL, md, relu, sc);
    checkOutput({tag, "_busy"}, 32'(busy), 32'd1);
    checkOutput({tag, "_sready"}, 32'(bus.s_ready), 32'd1);
    for (int n = 0; n < inEff/4; n++) sendBeat(pack4(xv[4*n], xv[4*n+1], xv[4*n+2], xv[4*n+3]), tag);
    for (int g = 0; g < groups; g++) begin
      sendGroupInputs(g, inEff, gap, tag);
      checkOutput({tag, "_firstValid"}, 32'(bus.m_valid), 32'd1);
      recvGroup(g*LANES, toggle, tag);
    end
    checkOutput({tag, "_done"}, 32'(done), 32'd1);
    checkOutput({tag, "_doneBusy"}, 32'(busy), 32'd1);
    @(negedge clk);
    checkOutput({tag, "_doneLow"}, 32'(done), 32'd0);
    checkOutput({tag, "_idle"}, 32'(busy), 32'd0);
  endtask

  task automatic zeroJob(input int inL, input int outL, input string tag);
    int seenReady = 0;
    int seenValid = 0;
    applyStimulus(inL, outL, 1'b1, 1'b0, 0);
    checkOutput({tag, "_done"}, 32'(done), 32'd1);
    for (int i = 0; i < 4; i++) begin
      if (bus.s_ready) seenReady++;
      if (bus.m_valid) seenValid++;
      @(negedge clk);
    end
    checkOutput({tag, "_sreadySeen"}, 32'(seenReady), 32'd0);
    checkOutput({tag, "_mvalidSeen"}, 32'(seenValid), 32'd0);
    checkOutput({tag, "_idle"}, 32'(busy), 32'd0);
  endtask

  task automatic checkResetOutputs(input string tag);
    checkOutput({tag, "_sready"}, 32'(bus.s_ready), 32'd0);
    checkOutput({tag, "_mvalid"}, 32'(bus.m_valid), 32'd0);
    checkOutput({tag, "_mdata"}, bus.m_data, 32'd0);
    checkOutput({tag, "_busy"}, 32'(busy), 32'd0);
    checkOutput({tag, "_done"}, 32'(done), 32'd0);
  endtask

  initial begin
    int acc;
    int biasReq [8] = '{290, -311, -110, 0, -10, -14, 50, -1010};
    logic [31:0] expReq [8] = '{32'h7F, 32'hFFFFFF80, 32'hFFFFFFCE, 32'h5,
                                32'h0, 32'hFFFFFFFE, 32'h1E, 32'hFFFFFF80};
    logic [31:0] expRelu [8] = '{32'h7F, 32'h0, 32'h0, 32'h5, 32'h0, 32'h0, 32'h1E, 32'h0};

    rst = 1'b1; start = 1'b0; mode = 1'b0; reluEn = 1'b0;
    inLen = '0; outLen = '0; scale = '0;
    bus.s_valid = 1'b0; bus.s_data = '0; bus.m_ready = 1'b1;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    checkResetOutputs("reset");

    // Raw accumulator: x=[1,2,3,4], w=1, bias=10 gives 20 per lane.
    for (int i = 0; i < 4; i++) xv[i] = i + 1;
    for (int n = 0; n < 16; n++) for (int k = 0; k < 64; k++) wv[n][k] = 1;
    for (int n = 0; n < 8; n++) begin bv[n] = 10; expQ[n] = 32'd20; end
    runJob(4, 8, 1'b1, 1'b0, 0, 0, 1'b0, "basic");

    // Requant with scale 2048: accumulator = bias + 10.
    for (int n = 0; n < 8; n++) begin bv[n] = biasReq[n]; expQ[n] = expReq[n]; end
    runJob(4, 8, 1'b0, 1'b0, 2048, 0, 1'b0, "requant");
    for (int n = 0; n < 8; n++) expQ[n] = expRelu[n];
    runJob(4, 8, 1'b0, 1'b1, 2048, 0, 1'b0, "requantRelu");

    // Two groups with odd lengths (9 -> 8, 19 -> 16), MAC gaps and m_ready toggling.
    xv[0] = 1; xv[1] = -1; xv[2] = 2; xv[3] = -2;
    xv[4] = 3; xv[5] = -3; xv[6] = 4; xv[7] = -4;
    for (int n = 0; n < 16; n++) begin
      bv[n] = n*100 - 700;
      acc = bv[n];
      for (int k = 0; k < 8; k++) begin
        wv[n][k] = n - k;
        acc += xv[k] * wv[n][k];
      end
      expQ[n] = 32'(acc);
    end
    runJob(9, 19, 1'b1, 1'b0, 0, 3, 1'b1, "stall");

    zeroJob(0, 8, "zeroIn");
    zeroJob(4, 7, "zeroOut");

    // in_len=70 clamps to 64; any extra LOAD_X beat would shift every later beat.
    for (int i = 0; i < 64; i++) xv[i] = 1;
    for (int l = 0; l < 8; l++) begin
      bv[l] = l;
      for (int k = 0; k < 64; k++) wv[l][k] = l - 3;
      expQ[l] = 32'(l + 64*(l - 3));
    end
    runJob(70, 8, 1'b1, 1'b0, 0, 0, 1'b0, "clamp");

    // Abort in MAC of the second group.
    for (int i = 0; i < 4; i++) xv[i] = i + 1;
    for (int n = 0; n < 16; n++) begin
      bv[n] = 10;
      expQ[n] = 32'd20;
      for (int k = 0; k < 4; k++) wv[n][k] = 1;
    end
    applyStimulus(4, 16, 1'b1, 1'b0, 0);
    sendBeat(pack4(xv[0], xv[1], xv[2], xv[3]), "abort");
    sendGroupInputs(0, 4, 0, "abort");
    recvGroup(0, 1'b0, "abortG0");
    for (int l = 0; l < LANES; l++) sendBeat(bv[8 + l], "abort");
    sendBeat(32'h01010101, "abort");
    rst = 1'b1;
    @(negedge clk);
    checkResetOutputs("abortRst");
    rst = 1'b0;
    @(negedge clk);

    // Fresh job after abort: accumulator wrap-around.
    for (int i = 0; i < 4; i++) xv[i] = 127;
    for (int n = 0; n < 8; n++) begin
      bv[n] = 32'h7FFFFFF0;
      expQ[n] = 32'h8000FBF4;
      for (int k = 0; k < 4; k++) wv[n][k] = 127;
    end
    runJob(4, 8, 1'b1, 1'b0, 0, 0, 1'b0, "wrap");

    $display("%0d/%0d checks passed", passCount, checkCount);
    $finish;
  end

endmodule
